// File: rtl/seq_pkg.sv
// Shared definitions for the ROM-to-UART character sequencer.
//   - seq_state_t : sequencer FSM state encoding
//   - ASCII_NUL   : string terminator; a NUL byte ends the stream untransmitted
//   - TIMER_W     : width of the latency/gap down-counter
//   - is_nul()    : terminator test on a captured ROM byte
package seq_pkg;

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      INIT      = 4'd1,
      READ      = 4'd2,
      WAIT_DATA = 4'd3,
      SEND      = 4'd4,
      WAIT_ACK  = 4'd5,
      WAIT_FREE = 4'd6,
      GAP       = 4'd7,
      DONE      = 4'd8
   } seq_state_t;

   localparam logic [7:0]  ASCII_NUL = 8'h00;
   localparam int unsigned TIMER_W   = 16;

   function automatic logic is_nul(input logic [7:0] b);
      return (b == ASCII_NUL);
   endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter used for both ROM read latency and inter-character gap.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val this edge (takes priority over counting)
//   load_val   : number of cycles to time
//   expire     : high during the last timed cycle (count == 1)
module cycle_timer
   import seq_pkg::*;
#(
   parameter int unsigned W = TIMER_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expire
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // next count: load, else decrement toward zero and park there
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != {W{1'b0}}) begin
         cnt_d = cnt_q - W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= {W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // a load of N gives N cycles with the final one flagged
   assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/rom_tx_sequencer.sv
// Streams bytes from a sequential-read ROM into a UART transmitter.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, abort      : begin streaming from address 0 / stop and return to IDLE
//   rom_init, rom_re  : ROM address reset pulse / read pulse
//   rom_dout, rom_end : ROM byte and last-byte flag, ROM_LATENCY cycles after rom_re
//   tx_busy           : UART busy; tx_send/tx_din request a character
//   busy, done        : streaming in progress / stream finished
//   char_count        : characters accepted by the UART since last start (saturating)
module rom_tx_sequencer
   import seq_pkg::*;
#(
   parameter int unsigned ROM_LATENCY = 1,
   parameter int unsigned GAP_CYCLES  = 0,
   parameter int unsigned COUNT_W     = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   output logic               rom_init,
   output logic               rom_re,
   input  logic [7:0]         rom_dout,
   input  logic               rom_end,
   input  logic               tx_busy,
   output logic               tx_send,
   output logic [7:0]         tx_din,
   output logic               busy,
   output logic               done,
   output logic [COUNT_W-1:0] char_count
);

   seq_state_t           state_q, state_d;
   logic                 rom_init_q, rom_init_d;
   logic                 rom_re_q, rom_re_d;
   logic                 tx_send_q, tx_send_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 last_q, last_d;
   logic [7:0]           tx_din_q, tx_din_d;
   logic [COUNT_W-1:0]   char_count_q, char_count_d;
   logic                 tmr_load_s;
   logic [TIMER_W-1:0]   tmr_val_s;
   logic                 tmr_expire_s;
   logic                 start_ok_s;

   assign start_ok_s = start && !abort && ((state_q == IDLE) || (state_q == DONE));

   cycle_timer #(.W(TIMER_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load_s),
      .load_val (tmr_val_s),
      .expire   (tmr_expire_s)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic; abort overrides every transition
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE, DONE: state_d = start ? INIT : state_q;
            INIT:       state_d = READ;
            READ:       state_d = WAIT_DATA;
            WAIT_DATA: begin
               if (tmr_expire_s) begin
                  // NUL terminates even when it also carries rom_end
                  state_d = is_nul(rom_dout) ? DONE : SEND;
               end else begin
                  state_d = WAIT_DATA;
               end
            end
            SEND:       state_d = tx_busy ? WAIT_ACK : SEND;
            WAIT_ACK:   state_d = tx_busy ? WAIT_ACK : WAIT_FREE;
            WAIT_FREE: begin
               if (last_q) begin
                  state_d = DONE;
               end else if (GAP_CYCLES == 0) begin
                  state_d = READ;
               end else begin
                  state_d = GAP;
               end
            end
            GAP:        state_d = tmr_expire_s ? READ : GAP;
            default:    state_d = IDLE;
         endcase
      end
   end

   // timer control: latency on leaving READ, gap on entering GAP
   always_comb begin
      tmr_load_s = 1'b0;
      tmr_val_s  = TIMER_W'(ROM_LATENCY);
      if (state_q == READ) begin
         tmr_load_s = 1'b1;
         tmr_val_s  = TIMER_W'(ROM_LATENCY);
      end else if ((state_q == WAIT_FREE) && (state_d == GAP)) begin
         tmr_load_s = 1'b1;
         tmr_val_s  = TIMER_W'(GAP_CYCLES);
      end else begin
         tmr_load_s = 1'b0;
         tmr_val_s  = TIMER_W'(ROM_LATENCY);
      end
   end

   // outputs decoded from the next state so they register alongside it
   always_comb begin
      rom_init_d   = (state_d == INIT);
      rom_re_d     = (state_d == READ);
      tx_send_d    = (state_d == SEND);
      busy_d       = !((state_d == IDLE) || (state_d == DONE));
      done_d       = (state_d == DONE);
      tx_din_d     = tx_din_q;
      last_d       = last_q;
      char_count_d = char_count_q;
      if (start_ok_s) begin
         char_count_d = {COUNT_W{1'b0}};
      end else if (abort) begin
         char_count_d = char_count_q;
      end else if ((state_q == WAIT_DATA) && tmr_expire_s) begin
         tx_din_d = rom_dout;
         last_d   = rom_end;
      end else if ((state_q == SEND) && tx_busy && (char_count_q != {COUNT_W{1'b1}})) begin
         // counted only on the SEND->WAIT_ACK edge, so once per character
         char_count_d = char_count_q + COUNT_W'(1);
      end else begin
         char_count_d = char_count_q;
      end
   end

   // output and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_init_q   <= 1'b0;
         rom_re_q     <= 1'b0;
         tx_send_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         last_q       <= 1'b0;
         tx_din_q     <= 8'h00;
         char_count_q <= {COUNT_W{1'b0}};
      end else begin
         rom_init_q   <= rom_init_d;
         rom_re_q     <= rom_re_d;
         tx_send_q    <= tx_send_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         last_q       <= last_d;
         tx_din_q     <= tx_din_d;
         char_count_q <= char_count_d;
      end
   end

   assign rom_init   = rom_init_q;
   assign rom_re     = rom_re_q;
   assign tx_send    = tx_send_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign tx_din     = tx_din_q;
   assign char_count = char_count_q;

endmodule
